snn_core_param: RTL and testbench

Parametrised two-layer spiking/MLP inference core: streams binary input pixels against hidden-layer weights and applies a LUT activation to each of `N_HID` hidden units. It then runs the hidden activations against output weights for `N_OUT` output units and reports the arg-max output index as `digit`. It replaces the fixed 784/32/10 core with configurable layer sizes. It adds an on-chip arg-max with its winning activation, and a `busy` flag. Weight ROMs, the activation LUT and the input memory are external, all synchronous-read with 1-cycle latency. The hidden-activation store is internal.

---
 rtl/snn_core_param.sv | 224 ++++++++++++++++++++++
 tb/tb_snn_core_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_core_param.sv
// Two-layer binary-input inference core with configurable layer sizes.
// Streams pixels and weights from external synchronous memories and reports the arg-max output.
module snn_core_param #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10,
  parameter int ACC_W = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           q_input,
  output logic [$clog2(N_IN)-1:0]        addr_input_unit,
  output logic [$clog2(N_IN*N_HID)-1:0]  addr_w_h,
  input  logic [7:0]                     w_h,
  output logic [$clog2(N_HID*N_OUT)-1:0] addr_w_o,
  input  logic [7:0]                     w_o,
  output logic [10:0]                    addr_act,
  input  logic [7:0]                     act_q,
  output logic                           busy,
  output logic                           done,
  output logic [3:0]                     digit,
  output logic [7:0]                     max_act
);

  localparam int IW  = $clog2(N_IN);
  localparam int HW  = $clog2(N_HID);
  localparam int OW  = $clog2(N_OUT);
  localparam int WHW = $clog2(N_IN*N_HID);
  localparam int WOW = $clog2(N_HID*N_OUT);
  localparam logic signed [ACC_W-1:0] ACT_HI = ACC_W'(12'sd1023);
  localparam logic signed [ACC_W-1:0] ACT_LO = ACC_W'(-12'sd1024);

  typedef enum logic [3:0] {
    S_IDLE, S_HID_MAC, S_HID_DRAIN, S_HID_ACT, S_HID_WR,
    S_OUT_MAC, S_OUT_DRAIN, S_OUT_ACT, S_OUT_WR, S_DONE
  } state_t;

  state_t                   state_r;
  logic [IW-1:0]            i_r;
  logic [HW-1:0]            h_r;
  logic [OW-1:0]            o_r;
  logic [WHW-1:0]           wh_addr_r;
  logic [WOW-1:0]           wo_addr_r;
  logic [10:0]              act_addr_r;
  logic                     busy_r;
  logic                     done_r;
  logic [3:0]               digit_r;
  logic [7:0]               max_act_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     prod_vld_r;
  logic [7:0]               hid_op_r;
  logic [7:0]               hidden_r [N_HID];

  logic                     out_phase_s;
  logic [7:0]               op_a_s;
  logic [7:0]               op_b_s;
  logic signed [16:0]       prod_s;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [ACC_W-1:0]  acc_shift_s;
  logic [10:0]              act_addr_s;
  logic                     i_last_s;
  logic                     h_last_s;
  logic                     o_last_s;

  assign i_last_s = (i_r == IW'(N_IN - 1));
  assign h_last_s = (h_r == HW'(N_HID - 1));
  assign o_last_s = (o_r == OW'(N_OUT - 1));

  assign addr_input_unit = i_r;
  assign addr_w_h        = wh_addr_r;
  assign addr_w_o        = wo_addr_r;
  assign addr_act        = act_addr_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign digit           = digit_r;
  assign max_act         = max_act_r;

  // Operand select, signed MAC step and clamped LUT address of the next accumulator value
  always_comb begin
    out_phase_s = (state_r == S_OUT_MAC) || (state_r == S_OUT_DRAIN);
    if (out_phase_s) begin
      op_a_s = hid_op_r;
      op_b_s = w_o;
    end else begin
      op_a_s = q_input ? 8'hFF : 8'h00;
      op_b_s = w_h;
    end
    prod_s      = $signed({9'b0, op_a_s}) * $signed({{9{op_b_s[7]}}, op_b_s});
    acc_next_s  = acc_r + {{(ACC_W-17){prod_s[16]}}, prod_s};
    acc_shift_s = acc_next_s >>> 3'd7;
    if (acc_shift_s > ACT_HI) begin
      act_addr_s = 11'd2047;
    end else if (acc_shift_s < ACT_LO) begin
      act_addr_s = 11'd0;
    end else begin
      act_addr_s = acc_shift_s[10:0] + 11'd1024;
    end
  end

  // Sequencer: state, loop counters, memory addresses, status and arg-max result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      i_r       <= '0;
      h_r       <= '0;
      o_r       <= '0;
      wh_addr_r <= '0;
      wo_addr_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      digit_r   <= 4'd0;
      max_act_r <= 8'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          i_r       <= '0;
          h_r       <= '0;
          o_r       <= '0;
          wh_addr_r <= '0;
          wo_addr_r <= '0;
          if (start) begin
            state_r <= S_HID_MAC;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_HID_MAC: begin
          if (i_last_s) begin
            i_r       <= '0;
            state_r   <= S_HID_DRAIN;
            // h*N_IN+i runs contiguously across units, so only the final unit wraps
            wh_addr_r <= h_last_s ? '0 : wh_addr_r + WHW'(1'b1);
          end else begin
            i_r       <= i_r + IW'(1'b1);
            wh_addr_r <= wh_addr_r + WHW'(1'b1);
          end
        end
        S_HID_DRAIN: state_r <= S_HID_ACT;
        S_HID_ACT:   state_r <= S_HID_WR;
        S_HID_WR: begin
          if (h_last_s) begin
            h_r     <= '0;
            state_r <= S_OUT_MAC;
          end else begin
            h_r     <= h_r + HW'(1'b1);
            state_r <= S_HID_MAC;
          end
        end
        S_OUT_MAC: begin
          if (h_last_s) begin
            h_r       <= '0;
            state_r   <= S_OUT_DRAIN;
            wo_addr_r <= o_last_s ? '0 : wo_addr_r + WOW'(1'b1);
          end else begin
            h_r       <= h_r + HW'(1'b1);
            wo_addr_r <= wo_addr_r + WOW'(1'b1);
          end
        end
        S_OUT_DRAIN: state_r <= S_OUT_ACT;
        S_OUT_ACT:   state_r <= S_OUT_WR;
        S_OUT_WR: begin
          if ((o_r == {OW{1'b0}}) || (act_q > max_act_r)) begin
            max_act_r <= act_q;
            digit_r   <= 4'(o_r);
          end
          if (o_last_s) begin
            o_r     <= '0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            o_r     <= o_r + OW'(1'b1);
            state_r <= S_OUT_MAC;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: memory data arrives one cycle after its address, hence the product-valid delay
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r      <= '0;
      prod_vld_r <= 1'b0;
      hid_op_r   <= 8'd0;
      act_addr_r <= 11'd0;
    end else begin
      prod_vld_r <= (state_r == S_HID_MAC) || (state_r == S_OUT_MAC);
      if (state_r == S_OUT_MAC) begin
        hid_op_r <= hidden_r[h_r];
      end
      case (state_r)
        S_IDLE, S_HID_WR, S_OUT_WR: acc_r <= '0;
        default: begin
          if (prod_vld_r) begin
            acc_r <= acc_next_s;
          end
        end
      endcase
      if ((state_r == S_HID_DRAIN) || (state_r == S_OUT_DRAIN)) begin
        act_addr_r <= act_addr_s;
      end
    end
  end

  // Hidden activation store, written once per hidden unit
  always_ff @(posedge clk) begin
    if (state_r == S_HID_WR) begin
      hidden_r[h_r] <= act_q;
    end
  end

endmodule

// File: tb/tb_snn_core_param.sv
// Scoreboard bench for snn_core_param: small config, external memories modelled here,
// cycle-keyed expectations checked by an independent monitor.
module tb_snn_core_param;
  localparam int N_IN  = 8;
  localparam int N_HID = 3;
  localparam int N_OUT = 10;
  localparam int ACC_W = 26;
  localparam int IW  = $clog2(N_IN);
  localparam int WHW = $clog2(N_IN*N_HID);
  localparam int WOW = $clog2(N_HID*N_OUT);
  localparam int LAT = N_HID*(N_IN+3) + N_OUT*(N_HID+3) + 1;  // 94
  localparam int B   = N_HID*(N_IN+3);                        // 33
  localparam int K_WH = 0, K_WO = 1, K_ACT = 2, K_IN = 3, K_BUSY = 4;

  logic clk = 1'b0;
  logic rst, start, q_input;
  logic [IW-1:0] addr_input_unit;
  logic [WHW-1:0] addr_w_h;
  logic [WOW-1:0] addr_w_o;
  logic [7:0] w_h, w_o, act_q, max_act;
  logic [10:0] addr_act;
  logic busy, done;
  logic [3:0] digit;

  logic       pix_m [0:(1<<IW)-1];
  logic [7:0] wh_m  [0:(1<<WHW)-1];
  logic [7:0] wo_m  [0:(1<<WOW)-1];

  typedef struct {int cyc; int kind; int val;} ev_t;
  typedef struct {int cyc; int dig; int mx;} dn_t;
  ev_t ev_q[$];
  dn_t dn_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  snn_core_param #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .q_input(q_input),
    .addr_input_unit(addr_input_unit), .addr_w_h(addr_w_h), .w_h(w_h),
    .addr_w_o(addr_w_o), .w_o(w_o), .addr_act(addr_act), .act_q(act_q),
    .busy(busy), .done(done), .digit(digit), .max_act(max_act)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External synchronous memories; the LUT returns address[10:3]
  always @(posedge clk) begin
    q_input <= pix_m[addr_input_unit];
    w_h     <= wh_m[addr_w_h];
    w_o     <= wo_m[addr_w_o];
    act_q   <= addr_act[10:3];
  end

  function void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Monitor: compares cycle-keyed expectations and every done pulse against the queues
  always @(posedge clk) begin : monitor
    dn_t d;
    #1;
    for (int k = ev_q.size() - 1; k >= 0; k--) begin
      if (ev_q[k].cyc < cyc) begin
        chk("missed_event_cycle", ev_q[k].cyc, cyc);
        ev_q.delete(k);
      end else if (ev_q[k].cyc == cyc) begin
        case (ev_q[k].kind)
          K_WH:    chk("addr_w_h", int'(addr_w_h), ev_q[k].val);
          K_WO:    chk("addr_w_o", int'(addr_w_o), ev_q[k].val);
          K_ACT:   chk("addr_act", int'(addr_act), ev_q[k].val);
          K_IN:    chk("addr_input_unit", int'(addr_input_unit), ev_q[k].val);
          default: chk("busy", int'(busy), ev_q[k].val);
        endcase
        ev_q.delete(k);
      end
    end
    if (done) begin
      if (dn_q.size() == 0) begin
        chk("unexpected_done_cycle", cyc, -1);
      end else begin
        d = dn_q.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("digit", int'(digit), d.dig);
        chk("max_act", int'(max_act), d.mx);
      end
    end
  end

  task automatic add_ev(input int c, input int kind, input int v);
    ev_q.push_back('{c, kind, v});
  endtask

  // Queue all expectations of one inference whose cycle 0 is base; events after limit are dropped
  task automatic push_run(input int base, input int hact0, input int oact_o, input int oact_v,
                          input int dig, input int mx, input int limit);
    if (1 <= limit) add_ev(base + 1, K_BUSY, 1);
    if (N_IN + 2 <= limit) add_ev(base + N_IN + 2, K_ACT, hact0);
    for (int k = 0; k < N_IN; k++) begin
      if (N_IN + 4 + k <= limit) begin
        add_ev(base + N_IN + 4 + k, K_WH, N_IN + k);
        add_ev(base + N_IN + 4 + k, K_IN, k);
      end
    end
    for (int k = 0; k < N_HID; k++) begin
      if (B + 2*(N_HID+3) + 1 + k <= limit) add_ev(base + B + 2*(N_HID+3) + 1 + k, K_WO, 2*N_HID + k);
    end
    if (oact_o >= 0 && B + oact_o*(N_HID+3) + N_HID + 2 <= limit)
      add_ev(base + B + oact_o*(N_HID+3) + N_HID + 2, K_ACT, oact_v);
    if (LAT + 1 <= limit) add_ev(base + LAT + 1, K_BUSY, 0);
    if (LAT <= limit) dn_q.push_back('{base + LAT, dig, mx});
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (dn_q.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (dn_q.size() != 0) begin
      chk("done_timeout_pending", dn_q.size(), 0);
      dn_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_max_act", int'(max_act), 0);
    chk("rst_addr_input_unit", int'(addr_input_unit), 0);
    chk("rst_addr_w_h", int'(addr_w_h), 0);
    chk("rst_addr_w_o", int'(addr_w_o), 0);
    chk("rst_addr_act", int'(addr_act), 0);
  endtask

  task automatic fill(input logic pix_on, input logic [7:0] whv, input logic [7:0] wov);
    for (int k = 0; k < (1<<IW); k++) pix_m[k] = pix_on;
    for (int k = 0; k < (1<<WHW); k++) wh_m[k] = whv;
    for (int k = 0; k < (1<<WOW); k++) wo_m[k] = wov;
  endtask

  task automatic launch(output int base);
    base = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    rst = 1'b1;
    start = 1'b0;
    fill(1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All weights zero: every activation is 128, tie resolves to output 0
    fill(1'b1, 8'd0, 8'd0);
    push_run(cyc, 1024, -1, 0, 0, 128, 1000);
    launch(base);
    wait_done(LAT + 20);

    // Positive saturation; only output 7 has weight
    fill(1'b1, 8'd127, 8'd0);
    for (int h = 0; h < N_HID; h++) wo_m[7*N_HID + h] = 8'd127;
    push_run(cyc, 2047, 7, 1783, 7, 222, 1000);
    launch(base);
    wait_done(LAT + 20);

    // Negative saturation: hidden activations all 0
    for (int k = 0; k < (1<<WHW); k++) wh_m[k] = 8'h80;
    push_run(cyc, 0, 7, 1024, 0, 128, 1000);
    launch(base);
    wait_done(LAT + 20);

    // Equal maxima at 3 and 5, negative o=0, start held for two back-to-back runs
    fill(1'b1, 8'd127, 8'd0);
    for (int h = 0; h < N_HID; h++) begin
      wo_m[0*N_HID + h] = 8'hC0;
      wo_m[3*N_HID + h] = 8'h40;
      wo_m[5*N_HID + h] = 8'h40;
      wo_m[8*N_HID + h] = 8'd10;
    end
    base = cyc;
    push_run(base, 2047, 0, 641, 3, 175, 1000);
    push_run(base + LAT + 1, 2047, 3, 1406, 3, 175, 1000);
    start = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    start = 1'b0;
    wait_done(LAT + 20);

    // Mixed pixels and per-unit weights, plus a start pulse while busy
    fill(1'b0, 8'd0, 8'd0);
    for (int i = 0; i < N_IN; i++) begin
      pix_m[i] = (i < 4);
      wh_m[0*N_IN + i] = (i < 4) ? 8'd100 : 8'h9C;
      wh_m[1*N_IN + i] = (i < 4) ? 8'hCE : 8'd127;
      wh_m[2*N_IN + i] = (i < 4) ? 8'd3 : 8'h80;
    end
    for (int h = 0; h < N_HID; h++) begin
      wo_m[1*N_HID + h] = 8'h80;
      wo_m[6*N_HID + h] = 8'd127;
    end
    wo_m[9*N_HID + 0] = 8'd127;
    base = cyc;
    push_run(base, 1820, 6, 1455, 6, 181, 1000);
    add_ev(base + 21, K_ACT, 625);
    add_ev(base + 32, K_ACT, 1047);
    add_ev(base + 44, K_ACT, 589);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT + 20);

    // Reset during OUT_MAC aborts without a done pulse
    fill(1'b1, 8'd0, 8'd0);
    base = cyc;
    push_run(base, 1024, -1, 0, 0, 128, 40);
    launch(base);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    repeat (LAT + 10) @(negedge clk);

    // Fresh start after the abort completes with full latency
    push_run(cyc, 1024, -1, 0, 0, 128, 1000);
    launch(base);
    wait_done(LAT + 20);

    chk("pending_events", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
